clap_detector: RTL and testbench

- Sits directly downstream of the audio input controller.
- Pops stereo samples from the controller's input FIFO using its available/read handshake, and computes the per-sample peak magnitude of left/right.
- Runs a threshold/holdoff state machine that emits clean single-cycle clap and double-clap events, a clap counter and a stretched LED drive.
- Replaces ad-hoc level comparison with debounced, rate-limited detection for the home-control logic.

---
 rtl/clap_detector.sv | 197 +++++++++++++++++++
 tb/tb_clap_detector.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/clap_detector.sv
// Clap detector: pops stereo samples from the audio-in FIFO, takes the peak
// magnitude and runs a threshold/holdoff FSM producing clap and double-clap events.
module clap_detector #(
  parameter int DATA_WIDTH            = 32,
  parameter int HOLDOFF_SAMPLES       = 2400,
  parameter int DOUBLE_WINDOW_SAMPLES = 24000,
  parameter int LED_HOLD_CYCLES       = 25000000
) (
  input  logic                  CLOCK_50,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic [DATA_WIDTH-2:0] threshold,
  input  logic                  audio_in_available,
  input  logic [DATA_WIDTH-1:0] left_channel_audio_in,
  input  logic [DATA_WIDTH-1:0] right_channel_audio_in,
  output logic                  read_audio_in,
  output logic                  clap_detected,
  output logic                  double_clap,
  output logic                  clap_led,
  output logic [7:0]            clap_count
);

  localparam int MW      = DATA_WIDTH - 1;
  localparam int CNT_MAX = (HOLDOFF_SAMPLES > DOUBLE_WINDOW_SAMPLES) ?
                           HOLDOFF_SAMPLES : DOUBLE_WINDOW_SAMPLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int LW      = (LED_HOLD_CYCLES > 1) ? $clog2(LED_HOLD_CYCLES) : 1;

  localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLDOFF_SAMPLES - 1);
  localparam logic [CW-1:0] WINDOW_LOAD = CW'(DOUBLE_WINDOW_SAMPLES - 1);
  localparam logic [LW-1:0] LED_LOAD    = LW'(LED_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {F_IDLE, F_POP, F_WAIT1, F_WAIT2} fetch_t;
  typedef enum logic [1:0] {D_ARMED, D_HOLD, D_WINDOW} detect_t;

  fetch_t  f_state, f_next;
  detect_t d_state, d_next;
  logic    latch;

  logic [DATA_WIDTH-1:0] s0_l, s0_r;
  logic                  s0_valid;
  logic [MW-1:0]         s1_l, s1_r;
  logic                  s1_valid;
  logic [MW-1:0]         peak;
  logic                  s2_hit, s2_valid;

  logic [CW-1:0] cnt, cnt_next;
  logic          pair, pair_next;
  logic          clap_next, double_next;
  logic [LW-1:0] led_cnt;

  // Magnitude with the most-negative input saturated to all-ones.
  function automatic logic [MW-1:0] magnitude(input logic [DATA_WIDTH-1:0] x);
    logic [DATA_WIDTH-1:0] neg;
    neg = -x;
    if (!x[DATA_WIDTH-1])
      return x[MW-1:0];
    else if (x[MW-1:0] == '0)
      return '1;
    else
      return neg[MW-1:0];
  endfunction

  // Fetch FSM: the two wait states cover the controller's available-flag lag.
  always_comb begin
    f_next = f_state;
    latch  = 1'b0;
    case (f_state)
      F_IDLE: begin
        if (enable && audio_in_available) begin
          latch  = 1'b1;
          f_next = F_POP;
        end
      end
      F_POP:   f_next = F_WAIT1;
      F_WAIT1: f_next = F_WAIT2;
      F_WAIT2: f_next = F_IDLE;
      default: f_next = F_IDLE;
    endcase
  end

  assign read_audio_in = (f_state == F_POP);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      f_state <= F_IDLE;
    end else begin
      f_state <= f_next;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      s0_l     <= '0;
      s0_r     <= '0;
      s0_valid <= 1'b0;
      s1_l     <= '0;
      s1_r     <= '0;
      s1_valid <= 1'b0;
      s2_hit   <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s0_valid <= latch;
      if (latch) begin
        s0_l <= left_channel_audio_in;
        s0_r <= right_channel_audio_in;
      end
      s1_valid <= s0_valid;
      s1_l     <= magnitude(s0_l);
      s1_r     <= magnitude(s0_r);
      s2_valid <= s1_valid;
      s2_hit   <= s1_valid && (peak > threshold);
    end
  end

  assign peak = (s1_l > s1_r) ? s1_l : s1_r;

  // Detect FSM: counter only moves on valid samples; a hit on the window's
  // last sample wins over expiry.
  always_comb begin
    d_next      = d_state;
    cnt_next    = cnt;
    pair_next   = pair;
    clap_next   = 1'b0;
    double_next = 1'b0;
    if (s2_valid) begin
      case (d_state)
        D_ARMED: begin
          if (s2_hit) begin
            clap_next = 1'b1;
            pair_next = 1'b0;
            cnt_next  = HOLD_LOAD;
            d_next    = D_HOLD;
          end
        end
        D_HOLD: begin
          if (cnt == '0) begin
            if (pair) begin
              d_next = D_ARMED;
            end else begin
              cnt_next = WINDOW_LOAD;
              d_next   = D_WINDOW;
            end
          end else begin
            cnt_next = cnt - CW'(1);
          end
        end
        D_WINDOW: begin
          if (s2_hit) begin
            clap_next   = 1'b1;
            double_next = 1'b1;
            pair_next   = 1'b1;
            cnt_next    = HOLD_LOAD;
            d_next      = D_HOLD;
          end else if (cnt == '0) begin
            d_next = D_ARMED;
          end else begin
            cnt_next = cnt - CW'(1);
          end
        end
        default: d_next = D_ARMED;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      d_state       <= D_ARMED;
      cnt           <= '0;
      pair          <= 1'b0;
      clap_detected <= 1'b0;
      double_clap   <= 1'b0;
      clap_count    <= '0;
    end else begin
      d_state       <= d_next;
      cnt           <= cnt_next;
      pair          <= pair_next;
      clap_detected <= clap_next;
      double_clap   <= double_next;
      if (clap_next) clap_count <= clap_count + 8'd1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      clap_led <= 1'b0;
      led_cnt  <= '0;
    end else if (clap_next) begin
      clap_led <= 1'b1;
      led_cnt  <= LED_LOAD;
    end else if (clap_led) begin
      if (led_cnt == '0) clap_led <= 1'b0;
      else               led_cnt  <= led_cnt - LW'(1);
    end
  end

endmodule

// File: tb/tb_clap_detector.sv
// Directed bench for clap_detector with short holdoff/window/LED timings.
module tb_clap_detector;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic [30:0] threshold;
  logic        avail;
  logic [31:0] samp_l, samp_r;
  logic        read_audio_in, clap_detected, double_clap, clap_led;
  logic [7:0]  clap_count;

  int total = 0;
  int bad   = 0;
  int exp_count = 0;

  clap_detector #(
    .DATA_WIDTH(32),
    .HOLDOFF_SAMPLES(4),
    .DOUBLE_WINDOW_SAMPLES(8),
    .LED_HOLD_CYCLES(48)
  ) dut (
    .CLOCK_50(clk),
    .resetn(resetn),
    .enable(enable),
    .threshold(threshold),
    .audio_in_available(avail),
    .left_channel_audio_in(samp_l),
    .right_channel_audio_in(samp_r),
    .read_audio_in(read_audio_in),
    .clap_detected(clap_detected),
    .double_clap(double_clap),
    .clap_led(clap_led),
    .clap_count(clap_count)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Offer one sample, wait for its pop, then check the result 3 edges after latch.
  task automatic send(input logic [31:0] l, input logic [31:0] r,
                      input logic exp_c, input logic exp_d);
    logic got;
    got    = 1'b0;
    samp_l = l;
    samp_r = r;
    avail  = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (read_audio_in) begin
        got = 1'b1;
        break;
      end
    end
    avail = 1'b0;
    check("pop", 32'(got), 1);
    @(posedge clk); #1;
    check("pop_once", 32'(read_audio_in), 0);
    @(posedge clk); #1;
    check("early", 32'(clap_detected), 0);
    @(posedge clk); #1;
    if (exp_c) exp_count = (exp_count + 1) % 256;
    check("clap", 32'(clap_detected), 32'(exp_c));
    check("dbl", 32'(double_clap), 32'(exp_d));
    check("count", 32'(clap_count), exp_count);
    if (exp_c) check("led_on", 32'(clap_led), 1);
  endtask

  initial begin
    int reads, claps, lo, g;
    logic seen;

    resetn = 1'b0; enable = 1'b0; threshold = 31'd1000; avail = 1'b0;
    samp_l = '0; samp_r = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_read", 32'(read_audio_in), 0);
    check("rst_clap", 32'(clap_detected), 0);
    check("rst_dbl", 32'(double_clap), 0);
    check("rst_led", 32'(clap_led), 0);
    check("rst_count", 32'(clap_count), 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Continuous availability of silent samples: one pop per 4 cycles.
    enable = 1'b1; avail = 1'b1; reads = 0; claps = 0;
    repeat (40) begin
      @(posedge clk); #1;
      reads += int'(read_audio_in);
      claps += int'(clap_detected);
    end
    avail = 1'b0;
    check("pop_rate", reads, 10);
    check("silent_claps", claps, 0);
    check("silent_count", 32'(clap_count), 0);
    repeat (8) @(posedge clk); #1;

    // Threshold equality, single clap, LED hold length.
    send(32'd1000, 32'd0, 1'b0, 1'b0);
    send(32'h0000_0400, 32'd0, 1'b1, 1'b0);
    repeat (47) @(posedge clk); #1;
    check("led_hold_end", 32'(clap_led), 1);
    @(posedge clk); #1;
    check("led_off", 32'(clap_led), 0);

    // Holdoff ignores hits, window hit is a double clap.
    send(32'd0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send(32'h0000_0400, 32'd0, 1'b0, 1'b0);
    send(32'd0, 32'd0, 1'b0, 1'b0);
    send(32'd0, 32'd0, 1'b0, 1'b0);
    send(32'h0000_0400, 32'd0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send(32'h0000_0400, 32'd0, 1'b0, 1'b0);
    send(32'd0, 32'h0000_0400, 1'b1, 1'b0);

    // Window expires with no hit, then a saturated most-negative sample claps.
    for (int i = 0; i < 12; i++) send(32'd0, 32'd0, 1'b0, 1'b0);
    threshold = 31'h7FFF_FFFE;
    send(32'h8000_0000, 32'd0, 1'b1, 1'b0);
    threshold = 31'd1000;

    // Hit on the last window sample (negative right channel) is a double.
    for (int i = 0; i < 11; i++) send(32'd0, 32'd0, 1'b0, 1'b0);
    send(32'd0, 32'hFFFF_F830, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send(32'd0, 32'd0, 1'b0, 1'b0);
    threshold = 31'h7FFF_FFFF;
    send(32'h8000_0000, 32'd0, 1'b0, 1'b0);
    threshold = 31'd1000;

    // Reset while popping and in holdoff.
    send(32'hFFFF_FC00, 32'd0, 1'b1, 1'b0);
    samp_l = 32'h0000_0400; avail = 1'b1; seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (read_audio_in) begin
        seen = 1'b1;
        break;
      end
    end
    check("pop_before_rst", 32'(seen), 1);
    resetn = 1'b0;
    #1;
    check("arst_read", 32'(read_audio_in), 0);
    check("arst_led", 32'(clap_led), 0);
    check("arst_count", 32'(clap_count), 0);
    check("arst_clap", 32'(clap_detected), 0);
    check("arst_dbl", 32'(double_clap), 0);
    exp_count = 0;
    avail = 1'b0;
    repeat (2) @(posedge clk); #1;
    resetn = 1'b1;
    reads = 0; claps = 0;
    repeat (8) begin
      @(posedge clk); #1;
      reads += int'(read_audio_in);
      claps += int'(clap_detected);
    end
    check("post_rst_reads", reads, 0);
    check("post_rst_claps", claps, 0);
    send(32'h0000_0400, 32'd0, 1'b1, 1'b0);

    // enable low blocks pops; dropping enable mid-sequence blocks the next.
    enable = 1'b0; avail = 1'b1; reads = 0;
    repeat (20) begin
      @(posedge clk); #1;
      reads += int'(read_audio_in);
    end
    check("disabled_reads", reads, 0);
    enable = 1'b1; seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (read_audio_in) begin
        seen = 1'b1;
        break;
      end
    end
    check("enable_pop", 32'(seen), 1);
    enable = 1'b0; reads = 0;
    repeat (12) begin
      @(posedge clk); #1;
      reads += int'(read_audio_in);
    end
    check("enable_drop_reads", reads, 0);
    avail = 1'b0;

    // Constant hit stream: clap/double alternate every 5 samples, count wraps.
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    enable = 1'b1; samp_l = 32'h0000_0400; samp_r = '0; avail = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (clap_detected) begin
        seen = 1'b1;
        break;
      end
    end
    check("stream_first", 32'(seen), 1);
    check("stream_first_dbl", 32'(double_clap), 0);
    lo = 0;
    for (int k = 1; k < 256; k++) begin
      g = 0; seen = 1'b0;
      while (!seen && g < 30) begin
        @(posedge clk); #1;
        g++;
        if (!clap_led) lo++;
        seen = clap_detected;
      end
      check("stream_gap", g, 20);
      check("stream_dbl", 32'(double_clap), k % 2);
    end
    check("wrap_count", 32'(clap_count), 0);
    check("led_continuous", lo, 0);
    avail = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
